// File: rtl/memwb_stage.sv
// MEM/WB pipeline register and write-back stage: load extraction, register-file write port, HI/LO.
// Optional macro MEMWB_LBU_EN adds the zero-extending load-byte-unsigned decode.
`timescale 1ns/1ps
module memwb_stage #(
    parameter logic [7:0] LB_OP  = 8'h90,
    parameter logic [7:0] LW_OP  = 8'h92
`ifdef MEMWB_LBU_EN
    ,
    parameter logic [7:0] LBU_OP = 8'h94
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [7:0]  mem_aluop_i,
    input  logic [4:0]  mem_wa_i,
    input  logic        mem_wreg_i,
    input  logic        mem_mreg_i,
    input  logic [31:0] mem_dreg_i,
    input  logic        mem_whilo_i,
    input  logic [63:0] mem_hilo_i,
    input  logic [31:0] dm_dout,
    output logic [4:0]  wb_wa_o,
    output logic        wb_wreg_o,
    output logic [31:0] wb_wd_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [7:0]  aluop_q;
    logic [4:0]  wa_q;
    logic        wreg_q;
    logic        mreg_q;
    logic [31:0] dreg_q;
    logic        whilo_q;
    logic [63:0] hilo_q;
    logic        fresh_q;
    logic [31:0] ld_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // NOTE: every register below updates with <= so all of them sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluop_q <= '0;
            wa_q    <= '0;
            wreg_q  <= 1'b0;
            mreg_q  <= 1'b0;
            dreg_q  <= '0;
            whilo_q <= 1'b0;
            hilo_q  <= '0;
            fresh_q <= 1'b0;
            ld_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (flush) begin
                aluop_q <= '0;
                wa_q    <= '0;
                wreg_q  <= 1'b0;
                mreg_q  <= 1'b0;
                dreg_q  <= '0;
                whilo_q <= 1'b0;
                hilo_q  <= '0;
            end else if (!stall) begin
                aluop_q <= mem_aluop_i;
                wa_q    <= mem_wa_i;
                wreg_q  <= mem_wreg_i;
                mreg_q  <= mem_mreg_i;
                dreg_q  <= mem_dreg_i;
                whilo_q <= mem_whilo_i;
                hilo_q  <= mem_hilo_i;
            end
            fresh_q <= !stall && !flush;
            // Memory output is only ours for one cycle; park it before MEM re-drives the RAM.
            if (fresh_q && stall) begin
                ld_q <= dm_dout;
            end
            // Committing only as the instruction leaves WB gives exactly one write per instruction.
            if (whilo_q && !stall && !flush) begin
                hi_q <= hilo_q[63:32];
                lo_q <= hilo_q[31:0];
            end
        end
    end

    logic [31:0] raw;
    logic [7:0]  lane;
    logic [31:0] load_data;

    // NOTE: defaults first on every comb output so no path leaves one unassigned (no latch).
    always_comb begin
        raw       = fresh_q ? dm_dout : ld_q;
        lane      = 8'h00;
        load_data = 32'h0;
        case (dreg_q[1:0])
            2'b00:   lane = raw[31:24];
            2'b01:   lane = raw[23:16];
            2'b10:   lane = raw[15:8];
            default: lane = raw[7:0];
        endcase
        if (aluop_q == LB_OP) begin
            load_data = {{24{lane[7]}}, lane};
        end else if (aluop_q == LW_OP) begin
            load_data = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
        end
`ifdef MEMWB_LBU_EN
        else if (aluop_q == LBU_OP) begin
            load_data = {24'h0, lane};
        end
`endif
    end

    assign wb_wa_o   = wa_q;
    assign wb_wreg_o = wreg_q;
    assign wb_wd_o   = mreg_q ? load_data : dreg_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: tb/tb_memwb_stage.sv
// Scoreboard bench for memwb_stage: loads, lanes, stall hold buffer, HI/LO commit, flush and reset.
`timescale 1ns/1ps
module tb_memwb_stage;

    localparam logic [7:0] LB_OP  = 8'h90;
    localparam logic [7:0] LW_OP  = 8'h92;
    localparam logic [7:0] LBU_OP = 8'h94;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  mem_aluop_i = '0;
    logic [4:0]  mem_wa_i = '0;
    logic        mem_wreg_i = 1'b0;
    logic        mem_mreg_i = 1'b0;
    logic [31:0] mem_dreg_i = '0;
    logic        mem_whilo_i = 1'b0;
    logic [63:0] mem_hilo_i = '0;
    logic [31:0] dm_dout = '0;
    logic [4:0]  wb_wa_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wd_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    memwb_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_aluop_i(mem_aluop_i), .mem_wa_i(mem_wa_i), .mem_wreg_i(mem_wreg_i),
        .mem_mreg_i(mem_mreg_i), .mem_dreg_i(mem_dreg_i), .mem_whilo_i(mem_whilo_i),
        .mem_hilo_i(mem_hilo_i), .dm_dout(dm_dout),
        .wb_wa_o(wb_wa_o), .wb_wreg_o(wb_wreg_o), .wb_wd_o(wb_wd_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wa;
        logic        wreg;
        logic [31:0] wd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [4:0] wa, input logic wreg, input logic [31:0] wd);
        exp_t e;
        e.wa = wa; e.wreg = wreg; e.wd = wd;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        check({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_wa"},   64'(wb_wa_o),   64'(e.wa));
            check({tag, "_wreg"}, 64'(wb_wreg_o), 64'(e.wreg));
            check({tag, "_wd"},   64'(wb_wd_o),   64'(e.wd));
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        check({tag, "_hi"}, 64'(hi_o), 64'(hi));
        check({tag, "_lo"}, 64'(lo_o), 64'(lo));
    endtask

    // Starts and ends at a falling edge: drive MEM, capture, then present memory data.
    task automatic issue(input string tag, input logic [7:0] aluop, input logic [4:0] wa,
                         input logic wreg, input logic mreg, input logic [31:0] dreg,
                         input logic whilo, input logic [63:0] hilo,
                         input logic [31:0] dm_next, input logic [31:0] exp_wd);
        stall = 1'b0; flush = 1'b0;
        mem_aluop_i = aluop; mem_wa_i = wa; mem_wreg_i = wreg; mem_mreg_i = mreg;
        mem_dreg_i = dreg; mem_whilo_i = whilo; mem_hilo_i = hilo;
        sb_push(wa, wreg, exp_wd);
        @(posedge clk);
        #1 dm_dout = dm_next;
        @(negedge clk);
        sb_check(tag);
    endtask

    task automatic nop(input string tag);
        issue(tag, 8'h00, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 32'h0, 32'h0);
    endtask

    // One edge with stall and/or flush asserted; the expected outputs are pushed beforehand.
    task automatic cycle(input logic st, input logic fl, input logic [31:0] dm_next);
        stall = st; flush = fl;
        @(posedge clk);
        #1 dm_dout = dm_next;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wa"},   64'(wb_wa_o),   64'd0);
        check({tag, "_wreg"}, 64'(wb_wreg_o), 64'd0);
        check({tag, "_wd"},   64'(wb_wd_o),   64'd0);
        check_hilo(tag, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] lbu_exp;
`ifdef MEMWB_LBU_EN
        lbu_exp = 32'h0000_0080;
`else
        lbu_exp = 32'h0000_0000;
`endif
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue("lw",      LW_OP, 5'd3,  1'b1, 1'b1, 32'h0000_0010, 1'b0, 64'h0, 32'h1122_3344, 32'h4433_2211);
        issue("lb_01",   LB_OP, 5'd4,  1'b1, 1'b1, 32'h0000_0101, 1'b0, 64'h0, 32'h00F0_0000, 32'hFFFF_FFF0);
        issue("lb_11",   LB_OP, 5'd5,  1'b1, 1'b1, 32'h0000_0013, 1'b0, 64'h0, 32'h0000_007F, 32'h0000_007F);
        issue("lb_00",   LB_OP, 5'd6,  1'b1, 1'b1, 32'h0000_0020, 1'b0, 64'h0, 32'h8000_0000, 32'hFFFF_FF80);
        issue("lb_10",   LB_OP, 5'd8,  1'b1, 1'b1, 32'h0000_0022, 1'b0, 64'h0, 32'h0000_1200, 32'h0000_0012);
        issue("alu",     8'h21, 5'd9,  1'b1, 1'b0, 32'hCAFE_0055, 1'b0, 64'h0, 32'h1234_5678, 32'hCAFE_0055);
        issue("unk_ld",  8'h33, 5'd10, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 64'h0, 32'hFFFF_FFFF, 32'h0);
        issue("lbu",     LBU_OP, 5'd11, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 64'h0, 32'h8000_0000, lbu_exp);

        // Load data must survive a stall while the memory output changes underneath it.
        issue("st_lw",   LW_OP, 5'd12, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 64'h0, 32'h1122_3344, 32'h4433_2211);
        for (int i = 0; i < 3; i++) begin
            sb_push(5'd12, 1'b1, 32'h4433_2211);
            cycle(1'b1, 1'b0, 32'hDEAD_BEEF);
            sb_check($sformatf("stall%0d", i));
        end

        issue("fl_lw",   LW_OP, 5'd13, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 64'h0, 32'hA1B2_C3D4, 32'hD4C3_B2A1);
        sb_push(5'd13, 1'b1, 32'hD4C3_B2A1);
        cycle(1'b1, 1'b0, 32'h0BAD_0BAD);
        sb_check("fl_hold");
        sb_push(5'd0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0BAD_0BAD);
        sb_check("fl_clear");

        issue("hilo_a",  8'h00, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1, 64'h0000_0001_0000_0002, 32'h0, 32'h0);
        check_hilo("hilo_cap", 32'h0, 32'h0);
        sb_push(5'd0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        sb_check("hilo_st");
        check_hilo("hilo_stall", 32'h0, 32'h0);
        nop("hilo_n1");
        check_hilo("hilo_wr", 32'h1, 32'h2);
        nop("hilo_n2");
        check_hilo("hilo_once", 32'h1, 32'h2);
        issue("hilo_b",  8'h00, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1, 64'h0000_0005_0000_0006, 32'h0, 32'h0);
        sb_push(5'd0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0);
        sb_check("hilo_fl");
        check_hilo("hilo_flush", 32'h1, 32'h2);
        nop("hilo_n3");
        check_hilo("hilo_after", 32'h1, 32'h2);

        issue("fs_alu",  8'h21, 5'd7, 1'b1, 1'b0, 32'h0000_0055, 1'b0, 64'h0, 32'h0, 32'h0000_0055);
        sb_push(5'd0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0);
        sb_check("fs_clear");

        // Asynchronous reset takes effect without waiting for a clock edge.
        issue("ar_alu",  8'h21, 5'd14, 1'b1, 1'b0, 32'h0000_0077, 1'b0, 64'h0, 32'h0, 32'h0000_0077);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        issue("rs_lw",   LW_OP, 5'd15, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 64'h0, 32'h5566_7788, 32'h8877_6655);
        sb_push(5'd15, 1'b1, 32'h8877_6655);
        cycle(1'b1, 1'b0, 32'h0);
        sb_check("rs_hold");
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb_push(5'd0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h5566_7788);
        sb_check("rs_after");

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
